// File: rtl/mmcm_lock_seq_pkg.sv
// mmcm_lock_seq_pkg: shared FSM state encodings and width helpers
// used by the MMCM reset/lock sequencer and its interface.
package mmcm_lock_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } seq_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // never returns a zero width, so 1-deep counters stay legal
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mmcm_lock_seq_if.sv
// mmcm_lock_seq_if: sequencer <-> MMCM wrapper / status consumer bundle.
// master: sequencer (drives mmcm_rst and status); slave: MMCM side.
interface mmcm_lock_seq_if #(
    parameter int MAX_RETRY = 7
) ();
    import mmcm_lock_seq_pkg::*;

    localparam int RW = width_of(MAX_RETRY + 1);

    logic          mmcm_unlocked;
    logic          mmcm_rst;
    logic          ready;
    logic [RW-1:0] retry_cnt;
    logic [7:0]    relock_cnt;
    logic          lock_err;

    modport master (
        input  mmcm_unlocked,
        output mmcm_rst,
        output ready,
        output retry_cnt,
        output relock_cnt,
        output lock_err
    );

    modport slave (
        output mmcm_unlocked,
        input  mmcm_rst,
        input  ready,
        input  retry_cnt,
        input  relock_cnt,
        input  lock_err
    );

endinterface

// File: rtl/mmcm_lock_seq_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer with a reset preset.
// Ports: clk, rst (sync, active high), d (async in), q (synchronized).
module sync_bit #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/mmcm_lock_seq.sv
// mmcm_lock_seq: MMCM reset pulse, lock wait with timeout/retry,
// lock qualification and relock. Ports: inclk, inrst, bus (master).
module mmcm_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 8000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              inclk,
    input  logic              inrst,
    mmcm_lock_seq_if.master   bus
);
    import mmcm_lock_seq_pkg::*;

    localparam int CW = width_of(max3(RST_CYCLES, LOCK_TIMEOUT,
                                      STABLE_CYCLES));
    localparam int RW = width_of(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

    logic          unlocked_s;
    logic          lk;
    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    relock_q, relock_d;
    logic          ready_q, rst_q, err_q;

    // preset to "unlocked" so nothing qualifies during reset
    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (inclk),
        .rst (inrst),
        .d   (bus.mmcm_unlocked),
        .q   (unlocked_s)
    );

    assign lk = ~unlocked_s;

    always_ff @(posedge inclk) begin
        if (inrst) begin
            state_q  <= ST_RESET;
            cnt_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
            ready_q  <= 1'b0;
            rst_q    <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
            // outputs follow the state being entered, not the current one
            ready_q  <= (state_d == ST_RUN);
            rst_q    <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            err_q    <= (state_d == ST_FAIL);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // lock beats a coincident timeout
                if (lk) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RTY_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_RESET;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STABLE: begin
                // a glitch only restarts qualification
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lk) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) relock_d = relock_q + 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.mmcm_rst   = rst_q;
    assign bus.ready      = ready_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.relock_cnt = relock_q;
    assign bus.lock_err   = err_q;

endmodule

// File: tb/tb_mmcm_lock_seq.sv
// tb_mmcm_lock_seq: scoreboard bench for mmcm_lock_seq using
// RST=4, TIMEOUT=32, STABLE=8, MAX_RETRY=2, SYNC=2.
module tb_mmcm_lock_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mmcm_lock_seq_if #(.MAX_RETRY(2)) bus ();

    mmcm_lock_seq #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2),
        .SYNC_STAGES   (2)
    ) dut (
        .inclk (clk),
        .inrst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_push = 0;
    int e0;

    localparam int S_RST   = 0;
    localparam int S_RDY   = 1;
    localparam int S_RTY   = 2;
    localparam int S_RLK   = 3;
    localparam int S_ERR   = 4;

    typedef struct packed {
        int c;
        int s;
        int v;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            S_RST:   return "mmcm_rst";
            S_RDY:   return "ready";
            S_RTY:   return "retry_cnt";
            S_RLK:   return "relock_cnt";
            default: return "lock_err";
        endcase
    endfunction

    function automatic int act_of(input int s);
        case (s)
            S_RST:   return int'(bus.mmcm_rst);
            S_RDY:   return int'(bus.ready);
            S_RTY:   return int'(bus.retry_cnt);
            S_RLK:   return int'(bus.relock_cnt);
            default: return int'(bus.lock_err);
        endcase
    endfunction

    task automatic push(input int c, input int s, input int v);
        sb.push_back('{c, s, v});
        if (c > last_push) last_push = c;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("%s@%0d", sig_name(e.s), e.c),
                act_of(e.s), e.v);
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic assert_rst();
        wait_cyc(last_push);
        @(negedge clk);
        rst = 1'b1;
        bus.mmcm_unlocked = 1'b1;
        push(cyc + 1, S_RST, 1);
        push(cyc + 1, S_RDY, 0);
        push(cyc + 1, S_RTY, 0);
        push(cyc + 1, S_RLK, 0);
        push(cyc + 1, S_ERR, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        e0 = cyc + 1;
        push(e0,     S_RST, 1);
        push(e0 + 1, S_RST, 1);
        push(e0 + 2, S_RST, 1);
        push(e0 + 3, S_RST, 0);
    endtask

    initial begin
        int r;
        int d;
        bus.mmcm_unlocked = 1'b1;

        // nominal lock, then loss in RUN and relock
        assert_rst();
        release_rst();
        wait_cyc(e0 + 13);
        bus.mmcm_unlocked = 1'b0;
        r = e0 + 24;
        push(r - 1, S_RDY, 0);
        push(r,     S_RDY, 1);
        push(r,     S_RTY, 0);
        push(r,     S_RST, 0);
        wait_cyc(r + 3);
        bus.mmcm_unlocked = 1'b1;
        push(r + 5, S_RDY, 1);
        push(r + 6, S_RDY, 0);
        push(r + 6, S_RST, 1);
        push(r + 6, S_RLK, 1);
        push(r + 6, S_RTY, 0);
        push(r + 9, S_RST, 1);
        push(r + 10, S_RST, 0);
        wait_cyc(r + 12);
        bus.mmcm_unlocked = 1'b0;
        push(r + 22, S_RDY, 0);
        push(r + 23, S_RDY, 1);
        push(r + 23, S_RLK, 1);

        // one-cycle glitch during STABLE
        assert_rst();
        release_rst();
        wait_cyc(e0 + 5);
        bus.mmcm_unlocked = 1'b0;
        wait_cyc(e0 + 12);
        bus.mmcm_unlocked = 1'b1;
        for (int t = e0 + 13; t <= e0 + 24; t++) begin
            push(t, S_RST, 0);
            push(t, S_RDY, (t == e0 + 24) ? 1 : 0);
        end
        push(e0 + 24, S_RTY, 0);
        push(e0 + 24, S_RLK, 0);
        wait_cyc(e0 + 13);
        bus.mmcm_unlocked = 1'b0;

        // first window times out, lock in the second
        assert_rst();
        release_rst();
        push(e0 + 34, S_RTY, 0);
        push(e0 + 35, S_RTY, 1);
        push(e0 + 35, S_RST, 1);
        push(e0 + 38, S_RST, 1);
        push(e0 + 39, S_RST, 0);
        wait_cyc(e0 + 44);
        bus.mmcm_unlocked = 1'b0;
        push(e0 + 54, S_RTY, 1);
        push(e0 + 54, S_RDY, 0);
        push(e0 + 55, S_RDY, 1);
        push(e0 + 55, S_RTY, 0);

        // never locks: three pulses then sticky error
        assert_rst();
        release_rst();
        for (int t = e0 + 4; t <= e0 + 125; t++) begin
            d = t - e0;
            push(t, S_RST, ((d >= 35 && d < 39) || (d >= 71 && d < 75) ||
                            d >= 107) ? 1 : 0);
            push(t, S_RDY, 0);
            push(t, S_RTY, (d < 35) ? 0 : (d < 71) ? 1 : 2);
            push(t, S_ERR, (d >= 107) ? 1 : 0);
        end

        // reset out of FAIL, then reset out of WAIT_LOCK
        assert_rst();
        release_rst();
        wait_cyc(e0 + 10);
        assert_rst();
        release_rst();

        wait_cyc(last_push + 1);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
